mips_main_control: RTL and testbench

- Multicycle main control FSM for the Small-MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath mux selects, write strobes and the 2-bit ALU-op code consumed by the ALU-control decoder.
- Sits between the instruction register opcode field and the datapath. Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/mips_ctrl_decode.sv | 66 ++++++
 rtl/mips_main_control.sv | 100 ++++++++++
 tb/tb_mips_main_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - Small-MIPS shared control encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Also consumed by the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational state to control-word table
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed here while the opcode is examined
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !is_legal_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// rtl/mips_main_control.sv - multicycle main control FSM with retire counter
module mips_main_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_opcode,
  input  logic             i_memReady,
  output logic             o_pcWrite,
  output logic             o_branch,
  output logic             o_irWrite,
  output logic             o_memWrite,
  output logic             o_regWrite,
  output logic             o_iorD,
  output logic             o_memToReg,
  output logic             o_regDst,
  output logic             o_aluSrcA,
  output logic [1:0]       o_aluSrcB,
  output logic [1:0]       o_pcSrc,
  output logic [1:0]       o_aluOp,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   retire;

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (i_opcode),
    .mem_ready (i_memReady),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = i_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (i_opcode == OP_LW)      state_d = S_MEMRD;
        else if (i_opcode == OP_SW) state_d = S_MEMWR;
        else                        state_d = S_FETCH;
      end
      S_MEMRD:  state_d = i_memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = i_memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = i_memReady;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      o_retired <= '0;
    end else begin
      state_q <= state_d;
      if (retire) o_retired <= o_retired + 1'b1;
    end
  end

  // Strobes are gated by reset so nothing leaks out while it is held low
  assign o_pcWrite  = ctrl.pc_write  & i_rst_n;
  assign o_branch   = ctrl.branch    & i_rst_n;
  assign o_irWrite  = ctrl.ir_write  & i_rst_n;
  assign o_memWrite = ctrl.mem_write & i_rst_n;
  assign o_regWrite = ctrl.reg_write & i_rst_n;
  assign o_illegal  = ctrl.illegal   & i_rst_n;
  assign o_iorD     = ctrl.iord;
  assign o_memToReg = ctrl.mem_to_reg;
  assign o_regDst   = ctrl.reg_dst;
  assign o_aluSrcA  = ctrl.alu_src_a;
  assign o_aluSrcB  = ctrl.alu_src_b;
  assign o_pcSrc    = ctrl.pc_src;
  assign o_aluOp    = ctrl.alu_op;

endmodule

// File: tb/tb_mips_main_control.sv
// tb/tb_mips_main_control.sv - scoreboard bench for the main control FSM
module tb_mips_main_control;

  localparam int CNT_W = 4;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [5:0]       i_opcode = RT;
  logic             i_memReady = 1'b1;
  logic             o_pcWrite, o_branch, o_irWrite, o_memWrite, o_regWrite;
  logic             o_iorD, o_memToReg, o_regDst, o_aluSrcA, o_illegal;
  logic [1:0]       o_aluSrcB, o_pcSrc, o_aluOp;
  logic [CNT_W-1:0] o_retired;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  ret;
    string       name;
  } exp_t;
  exp_t sb[$];

  mips_main_control #(.CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_opcode   (i_opcode),
    .i_memReady (i_memReady),
    .o_pcWrite  (o_pcWrite),
    .o_branch   (o_branch),
    .o_irWrite  (o_irWrite),
    .o_memWrite (o_memWrite),
    .o_regWrite (o_regWrite),
    .o_iorD     (o_iorD),
    .o_memToReg (o_memToReg),
    .o_regDst   (o_regDst),
    .o_aluSrcA  (o_aluSrcA),
    .o_aluSrcB  (o_aluSrcB),
    .o_pcSrc    (o_pcSrc),
    .o_aluOp    (o_aluOp),
    .o_illegal  (o_illegal),
    .o_retired  (o_retired)
  );

  always #5 i_clk = ~i_clk;

  // Word: {pcW,br,irW,memW,regW,iorD,m2r,regDst,srcA,srcB[2],pcSrc[2],aluOp[2],illegal}
  function automatic logic [15:0] exp_word(input int st, input logic rdy, input logic ill);
    logic pcw, br, irw, mw, rw, iord, m2r, rd, sa, il;
    logic [1:0] sb_, ps, ao;
    {pcw, br, irw, mw, rw, iord, m2r, rd, sa, il} = '0;
    sb_ = 2'b00; ps = 2'b00; ao = 2'b00;
    case (st)
      FETCH:  begin sb_ = 2'b01; pcw = rdy; irw = rdy; end
      DECODE: begin sb_ = 2'b11; il = ill; end
      MEMADR: begin sa = 1; sb_ = 2'b10; end
      MEMRD:  iord = 1;
      MEMWB:  begin m2r = 1; rw = 1; end
      MEMWR:  begin iord = 1; mw = 1; end
      EXEC:   begin sa = 1; ao = 2'b10; end
      ALUWB:  begin rd = 1; rw = 1; end
      BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      ADDIEX: begin sa = 1; sb_ = 2'b10; end
      ADDIWB: rw = 1;
      JUMP:   begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, br, irw, mw, rw, iord, m2r, rd, sa, sb_, ps, ao, il};
  endfunction

  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input int st, input logic ill, input logic [3:0] ret, input string nm);
    exp_t e;
    i_rst_n    = rst;
    i_opcode   = op;
    i_memReady = rdy;
    e.word = exp_word(st, rdy, ill);
    if (!rst) e.word = e.word & 16'b0000_0111_1111_1110;
    e.ret  = ret;
    e.name = nm;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = {o_pcWrite, o_branch, o_irWrite, o_memWrite, o_regWrite, o_iorD, o_memToReg,
             o_regDst, o_aluSrcA, o_aluSrcB, o_pcSrc, o_aluOp, o_illegal};
      checks++;
      if (act !== e.word) begin
        errors++;
        $display("FAIL %s ctrl: got %b want %b", e.name, act, e.word);
      end
      checks++;
      if (o_retired !== e.ret) begin
        errors++;
        $display("FAIL %s retired: got %0d want %0d", e.name, o_retired, e.ret);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge i_clk); #1;
    step(0, RT, 1, FETCH, 0, 0, "reset0");
    step(0, RT, 1, FETCH, 0, 0, "reset1");
    // R-type
    step(1, RT, 1, FETCH,  0, 0, "rt_fetch");
    step(1, RT, 1, DECODE, 0, 0, "rt_decode");
    step(1, RT, 1, EXEC,   0, 0, "rt_exec");
    step(1, RT, 1, ALUWB,  0, 0, "rt_aluwb");
    // LW with stalls in FETCH and MEMRD: MEMWB is the 10th cycle
    for (int i = 0; i < 3; i++) step(1, LW, 0, FETCH, 0, 1, "lw_fetch_wait");
    step(1, LW, 1, FETCH,  0, 1, "lw_fetch");
    step(1, LW, 1, DECODE, 0, 1, "lw_decode");
    step(1, LW, 1, MEMADR, 0, 1, "lw_memadr");
    for (int i = 0; i < 2; i++) step(1, LW, 0, MEMRD, 0, 1, "lw_memrd_wait");
    step(1, LW, 1, MEMRD,  0, 1, "lw_memrd");
    step(1, LW, 1, MEMWB,  0, 1, "lw_memwb");
    // SW
    step(1, SW, 1, FETCH,  0, 2, "sw_fetch");
    step(1, SW, 1, DECODE, 0, 2, "sw_decode");
    step(1, SW, 1, MEMADR, 0, 2, "sw_memadr");
    step(1, SW, 1, MEMWR,  0, 2, "sw_memwr");
    // BEQ then J
    step(1, BEQ, 1, FETCH,  0, 3, "beq_fetch");
    step(1, BEQ, 1, DECODE, 0, 3, "beq_decode");
    step(1, BEQ, 1, BRANCH, 0, 3, "beq_branch");
    step(1, JMP, 1, FETCH,  0, 4, "j_fetch");
    step(1, JMP, 1, DECODE, 0, 4, "j_decode");
    step(1, JMP, 1, JUMP,   0, 4, "j_jump");
    // Illegal opcode does not retire
    step(1, BAD, 1, FETCH,  0, 5, "bad_fetch");
    step(1, BAD, 1, DECODE, 1, 5, "bad_decode");
    // Reset asserted mid-MEMRD takes effect before the next edge
    step(1, LW, 1, FETCH,  0, 5, "lw2_fetch");
    step(1, LW, 1, DECODE, 0, 5, "lw2_decode");
    step(1, LW, 1, MEMADR, 0, 5, "lw2_memadr");
    step(1, LW, 0, MEMRD,  0, 5, "lw2_memrd");
    step(0, LW, 1, FETCH,  0, 0, "mid_reset");
    step(0, LW, 1, FETCH,  0, 0, "mid_reset_hold");
    // 16 ADDIs wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      step(1, ADDI, 1, FETCH,  0, 4'(i), "addi_fetch");
      step(1, ADDI, 1, DECODE, 0, 4'(i), "addi_decode");
      step(1, ADDI, 1, ADDIEX, 0, 4'(i), "addi_ex");
      step(1, ADDI, 1, ADDIWB, 0, 4'(i), "addi_wb");
    end
    step(1, RT, 0, FETCH, 0, 0, "wrap_fetch");
    @(negedge i_clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
